periph_bus_initiator: RTL

//  Bus initiator (master) for the peripheral register bus served by gpio and the

---
 rtl/periph_bus_initiator.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/periph_bus_initiator.sv
// periph_bus_initiator
//   Bus initiator for the peripheral register bus. Read/write commands arrive
//   on a valid/ready request port and wait in a small FIFO. Each command is
//   then driven onto the bus (we_o/addr_o/data_o) using the responder's read
//   timing. The write ack or the read data goes back, in command order, on a
//   valid/ready response port. Only one command is on the bus at a time.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid_i / req_ready_o      command handshake
//   req_we_i, req_addr_i, req_data_i  command type, address, write data
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_we_o, rsp_data_o           echoed type, read data or echoed write data
//   we_o, addr_o, data_o           bus toward the responder
//   data_i                         registered read data from the responder

module periph_bus_initiator #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned READ_LAT   = 1,
    parameter logic [31:0] IDLE_ADDR  = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_we_o,
    output logic [31:0] rsp_data_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LAT_W = $clog2(READ_LAT + 1);

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_WAIT = 2'd2,
        RSP     = 2'd3
    } state_t;

    cmd_t               fifo_q [FIFO_DEPTH];
    cmd_t               fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_we_q, rsp_we_d;
    logic [31:0]        rsp_data_q, rsp_data_d;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    cmd_t               head;

    // Fullness comes from the registered count only, so a pop in the same
    // cycle never opens room for a push while the FIFO is full.
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = req_valid_i && !full;
    assign pop   = (state_q == IDLE) && !empty;
    assign head  = fifo_q[rd_ptr_q];

    // FIFO storage, pointers and occupancy. Pointers wrap naturally because
    // the depth is a power of two.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {req_we_i, req_addr_i, req_data_i};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Bus sequencing. Every bus and response output is a register loaded
    // here, so outputs change only on clock edges and hold while stalled.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    we_d      = head.we;
                    addr_d    = head.addr;
                    data_d    = head.we ? head.data : 32'h0;
                    lat_cnt_d = '0;
                    state_d   = head.we ? WRITE : RD_WAIT;
                end else begin
                    we_d   = 1'b0;
                    addr_d = IDLE_ADDR;
                end
            end
            WRITE: begin
                we_d        = 1'b0;
                addr_d      = IDLE_ADDR;
                rsp_valid_d = 1'b1;
                rsp_we_d    = 1'b1;
                rsp_data_d  = data_q;
                state_d     = RSP;
            end
            RD_WAIT: begin
                // The address stays on the bus for READ_LAT+1 cycles; data_i
                // is sampled on the last of them.
                if (lat_cnt_q == LAT_W'(READ_LAT)) begin
                    addr_d      = IDLE_ADDR;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = 1'b0;
                    rsp_data_d  = data_i;
                    state_d     = RSP;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO payload needs no reset; entries are read only after being pushed.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    // Control and output registers. Reset mid-operation abandons the bus
    // cycle and drops any pending response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            we_q        <= 1'b0;
            addr_q      <= IDLE_ADDR;
            data_q      <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_data_q  <= 32'h0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready_o = !full;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_we_o    = rsp_we_q;
    assign rsp_data_o  = rsp_data_q;
    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign data_o      = data_q;

endmodule
